// File: rtl/wb_line_cache.sv
// Direct-mapped write-back/write-allocate line cache between a 128-bit wishbone CPU port and memory.
// Optional hit/miss counters are compiled in when CACHE_STATS_EN is defined.
module wb_line_cache #(
    parameter int IDX_W  = 3,
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    // cpu_to_cache (slave)
    input  logic              cpu_cyc_i,
    input  logic              cpu_stb_i,
    input  logic              cpu_we_i,
    input  logic [15:0]       cpu_sel_i,
    input  logic [ADDR_W-1:0] cpu_adr_i,
    input  logic [127:0]      cpu_dat_i,
    output logic              cpu_ack_o,
    output logic [127:0]      cpu_dat_o,
    // cache_to_mem (master)
    output logic              mem_cyc_o,
    output logic              mem_stb_o,
    output logic              mem_we_o,
    output logic [15:0]       mem_sel_o,
    output logic [ADDR_W-1:0] mem_adr_o,
    output logic [127:0]      mem_dat_o,
    input  logic              mem_ack_i,
    input  logic [127:0]      mem_dat_i,
    output logic [15:0]       hit_count,
    output logic [15:0]       miss_count
);
    localparam int SETS  = 1 << IDX_W;
    localparam int TAG_W = ADDR_W - 4 - IDX_W;

    typedef enum logic [2:0] {IDLE, LOOKUP, WRITEBACK, FILL, RESPOND} state_t;
    state_t state_q, state_d;

    logic [ADDR_W-1:0] req_adr_q;
    logic              req_we_q;
    logic [15:0]       req_sel_q;
    logic [127:0]      req_dat_q;

    logic [127:0]      data_q [SETS];
    logic [TAG_W-1:0]  tag_q  [SETS];
    logic [SETS-1:0]   valid_q, dirty_q;

    logic              mem_cyc_q, mem_cyc_d, mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_adr_q, mem_adr_d;
    logic [127:0]      mem_dat_q, mem_dat_d;

    logic [TAG_W-1:0]  req_tag;
    logic [IDX_W-1:0]  req_idx;
    logic [3:0]        req_off;
    logic [127:0]      merged;
    logic              hit, mem_done, fill_done, wr_hit;

    assign req_tag   = req_adr_q[ADDR_W-1:4+IDX_W];
    assign req_idx   = req_adr_q[4+IDX_W-1:4];
    assign req_off   = req_adr_q[3:0];
    assign hit       = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
    // A mem ACK only counts while our own cycle is on the bus.
    assign mem_done  = mem_ack_i && mem_cyc_q;
    assign fill_done = (state_q == FILL) && mem_done;
    assign wr_hit    = (state_q == LOOKUP) && hit && req_we_q;

    // CPU SEL is active-low: a cleared bit selects the new byte.
    always_comb begin
        merged = data_q[req_idx];
        for (int i = 0; i < 16; i++) begin
            if (!req_sel_q[i]) merged[8*i +: 8] = req_dat_q[8*i +: 8];
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:      if (cpu_cyc_i && cpu_stb_i) state_d = LOOKUP;
            LOOKUP:    if (hit)                    state_d = RESPOND;
                       else if (dirty_q[req_idx])  state_d = WRITEBACK;
                       else                        state_d = FILL;
            WRITEBACK: if (mem_done)               state_d = FILL;
            FILL:      if (mem_done)               state_d = LOOKUP;
            RESPOND:                               state_d = IDLE;
            default:                               state_d = IDLE;
        endcase
    end

    // Bus outputs are registered from the next state; each ACK drops CYC for one cycle.
    always_comb begin
        mem_cyc_d = ((state_d == WRITEBACK) || (state_d == FILL)) && !mem_done;
        mem_we_d  = mem_cyc_d && (state_d == WRITEBACK);
        mem_adr_d = (state_d == WRITEBACK) ? {tag_q[req_idx], req_idx, 4'b0000}
                                           : {req_tag, req_idx, 4'b0000};
        mem_dat_d = data_q[req_idx];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            mem_cyc_q <= 1'b0;
            mem_we_q  <= 1'b0;
            mem_adr_q <= '0;
            mem_dat_q <= '0;
            valid_q   <= '0;
            dirty_q   <= '0;
            req_adr_q <= '0;
            req_we_q  <= 1'b0;
            req_sel_q <= '1;
            req_dat_q <= '0;
        end else begin
            state_q   <= state_d;
            mem_cyc_q <= mem_cyc_d;
            mem_we_q  <= mem_we_d;
            mem_adr_q <= mem_adr_d;
            mem_dat_q <= mem_dat_d;
            if (state_q == IDLE && cpu_cyc_i && cpu_stb_i) begin
                req_adr_q <= cpu_adr_i;
                req_we_q  <= cpu_we_i;
                req_sel_q <= cpu_sel_i;
                req_dat_q <= cpu_dat_i;
            end
            if (wr_hit) dirty_q[req_idx] <= 1'b1;
            if (fill_done) begin
                valid_q[req_idx] <= 1'b1;
                dirty_q[req_idx] <= 1'b0;
            end
        end
    end

    // Line and tag storage carry no reset; valid bits guard them.
    always_ff @(posedge clk) begin
        if (wr_hit) data_q[req_idx] <= merged;
        if (fill_done) begin
            data_q[req_idx] <= mem_dat_i;
            tag_q[req_idx]  <= req_tag;
        end
    end

    assign cpu_ack_o = (state_q == RESPOND);
    assign cpu_dat_o = cpu_ack_o ? (data_q[req_idx] >> {req_off, 3'b000}) : '0;

    assign mem_cyc_o = mem_cyc_q;
    assign mem_stb_o = mem_cyc_q;
    assign mem_we_o  = mem_we_q;
    assign mem_sel_o = 16'hFFFF;
    assign mem_adr_o = mem_adr_q;
    assign mem_dat_o = mem_dat_q;

`ifdef CACHE_STATS_EN
    logic [15:0] hit_cnt_q, miss_cnt_q;
    logic        relookup_q;

    // The LOOKUP right after a fill always hits and is not a new access.
    always_ff @(posedge clk) begin
        if (rst) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
            relookup_q <= 1'b0;
        end else begin
            relookup_q <= fill_done;
            if (state_q == LOOKUP && !relookup_q) begin
                if (hit) begin
                    if (hit_cnt_q != 16'hFFFF) hit_cnt_q <= hit_cnt_q + 16'd1;
                end else begin
                    if (miss_cnt_q != 16'hFFFF) miss_cnt_q <= miss_cnt_q + 16'd1;
                end
            end
        end
    end

    assign hit_count  = hit_cnt_q;
    assign miss_count = miss_cnt_q;
`else
    assign hit_count  = 16'h0000;
    assign miss_count = 16'h0000;
`endif

endmodule
